// File: rtl/chs_pwm_controller_pkg.sv
// rtl/chs_pwm_controller_pkg.sv - shared types and constants for the fan/PWM controller
//
// Purpose: channel state encoding and cool/heat mode constants used by
//          chs_pwm_channel and chs_pwm_controller.
// Contents:
//   ch_state_e  per-channel state (IDLE, KICK, RAMP, HOLD)
//   MODE_COOL   chs_mode value for cooling (1)
//   MODE_HEAT   chs_mode value for heating (0), also the reset mode
package chs_pkg;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_KICK = 2'd1,
        CH_RAMP = 2'd2,
        CH_HOLD = 2'd3
    } ch_state_e;

    localparam logic MODE_COOL = 1'b1;
    localparam logic MODE_HEAT = 1'b0;

endpackage

// File: rtl/chs_pwm_channel.sv
// rtl/chs_pwm_channel.sv - one fan channel: target, duty ramp, start-up kick, PWM compare
//
// Purpose: holds the loaded duty target, walks the applied duty toward the
//          effective target one step per ramp tick, and drives a full-on kick
//          pulse when a stopped fan is started.
// Ports:
//   i_clk, i_arst   clock, synchronous active-high reset
//   i_load          capture i_speed into the target register
//   i_speed         new target for this channel
//   i_run           1 = loaded target is in effect, 0 = effective target is 0
//   i_tick          ramp step strobe (one cycle wide)
//   i_cnt           shared PWM counter
//   o_pwm           registered PWM output
//   o_duty          applied duty
//   o_idle          channel is stopped
//   o_active        channel is kicking or ramping
module chs_pwm_channel
    import chs_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int KICK_CYCLES = 64
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_speed,
    input  logic             i_run,
    input  logic             i_tick,
    input  logic [WIDTH-1:0] i_cnt,
    output logic             o_pwm,
    output logic [WIDTH-1:0] o_duty,
    output logic             o_idle,
    output logic             o_active
);

    localparam int              KW        = $clog2(KICK_CYCLES + 1);
    localparam logic [KW-1:0]   KICK_LAST = KW'(KICK_CYCLES - 1);
    localparam logic [KW-1:0]   KICK_ONE  = KW'(1);
    localparam logic [WIDTH-1:0] DUTY_ONE = WIDTH'(1);

    ch_state_e        r_state;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_duty;
    logic [KW-1:0]    r_kick;
    logic             r_pwm;

    logic [WIDTH-1:0] w_eff;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_dn;
    logic             w_eff_zero;

    always_comb begin
        w_eff      = i_run ? r_target : '0;
        w_eff_zero = (w_eff == '0);
        // Only used when duty is strictly below/above the target, so these
        // never wrap: stepping saturates at the target itself.
        w_up       = r_duty + DUTY_ONE;
        w_dn       = r_duty - DUTY_ONE;
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_state  <= CH_IDLE;
            r_target <= '0;
            r_duty   <= '0;
            r_kick   <= '0;
            r_pwm    <= 1'b0;
        end else begin
            if (i_load) begin
                r_target <= i_speed;
            end

            // Kick forces full-on, but only while it is still wanted so an
            // aborted start drops the pin together with the return to IDLE.
            r_pwm <= ((r_state == CH_KICK) && !w_eff_zero) || (i_cnt < r_duty);

            case (r_state)
                CH_IDLE: begin
                    r_duty <= '0;
                    if (!w_eff_zero) begin
                        r_state <= CH_KICK;
                        r_kick  <= KICK_LAST;
                    end
                end
                CH_KICK: begin
                    if (w_eff_zero) begin
                        r_state <= CH_IDLE;
                        r_kick  <= '0;
                    end else if (r_kick == '0) begin
                        r_state <= CH_RAMP;
                    end else begin
                        r_kick <= r_kick - KICK_ONE;
                    end
                end
                CH_RAMP: begin
                    if (r_duty == w_eff) begin
                        r_state <= w_eff_zero ? CH_IDLE : CH_HOLD;
                    end else if (i_tick) begin
                        if (r_duty < w_eff) begin
                            r_duty <= w_up;
                            if (w_up == w_eff) begin
                                r_state <= CH_HOLD;
                            end
                        end else begin
                            r_duty <= w_dn;
                            if (w_dn == w_eff) begin
                                r_state <= w_eff_zero ? CH_IDLE : CH_HOLD;
                            end
                        end
                    end
                end
                CH_HOLD: begin
                    if (r_duty != w_eff) begin
                        r_state <= CH_RAMP;
                    end
                end
                default: r_state <= CH_IDLE;
            endcase
        end
    end

    assign o_pwm    = r_pwm;
    assign o_duty   = r_duty;
    assign o_idle   = (r_state == CH_IDLE);
    assign o_active = (r_state == CH_KICK) || (r_state == CH_RAMP);

endmodule

// File: rtl/chs_pwm_controller.sv
// rtl/chs_pwm_controller.sv - multi-channel fan PWM driver with ramping and safe cool/heat changeover
//
// Purpose: shared PWM counter and ramp divider, cool/heat mode register with
//          changeover sequencing (ramp all fans to zero, flip, resume), and
//          CHANNELS instances of chs_pwm_channel.
// Ports:
//   i_clk, i_arst   clock, synchronous active-high reset
//   i_enable        global run; 0 ramps every fan down to stop
//   i_mode_in       requested mode (1 = cool, 0 = heat)
//   i_load          capture i_speed into all channel targets
//   i_speed         packed targets, channel i at [i*WIDTH +: WIDTH]
//   o_pwm_out       registered PWM pins
//   o_duty          packed applied duty per channel
//   o_chs_mode      active mode
//   o_busy          any channel kicking/ramping or a mode change pending
module chs_pwm_controller
    import chs_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int RAMP_DIV    = 16,
    parameter int KICK_CYCLES = 64
) (
    input  logic                      i_clk,
    input  logic                      i_arst,
    input  logic                      i_enable,
    input  logic                      i_mode_in,
    input  logic                      i_load,
    input  logic [CHANNELS*WIDTH-1:0] i_speed,
    output logic [CHANNELS-1:0]       o_pwm_out,
    output logic [CHANNELS*WIDTH-1:0] o_duty,
    output logic                      o_chs_mode,
    output logic                      o_busy
);

    localparam int               DW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DW-1:0]    DIV_LAST = DW'(RAMP_DIV - 1);
    localparam logic [DW-1:0]    DIV_ONE  = DW'(1);
    // Period is 2^WIDTH-1 so a full-scale duty keeps the pin constantly high.
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((1 << WIDTH) - 2);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic [DW-1:0]    r_div;
    logic             r_chs_mode;
    logic             r_pending;

    logic                      w_tick;
    logic                      w_run;
    logic                      w_all_idle;
    logic [CHANNELS-1:0]       w_pwm;
    logic [CHANNELS-1:0]       w_idle;
    logic [CHANNELS-1:0]       w_active;
    logic [CHANNELS*WIDTH-1:0] w_duty;

    assign w_tick     = (r_div == DIV_LAST);
    assign w_run      = i_enable && !r_pending;
    assign w_all_idle = &w_idle;

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_cnt      <= '0;
            r_div      <= '0;
            r_chs_mode <= MODE_HEAT;
            r_pending  <= 1'b0;
        end else begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
            r_div <= w_tick ? '0 : r_div + DIV_ONE;

            // Pending holds every fan at effective target 0; the flip waits
            // until the last one has actually stopped.
            if (r_pending) begin
                if (i_mode_in == r_chs_mode) begin
                    r_pending <= 1'b0;
                end else if (w_all_idle) begin
                    r_chs_mode <= i_mode_in;
                    r_pending  <= 1'b0;
                end
            end else if (i_mode_in != r_chs_mode) begin
                r_pending <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        chs_pwm_channel #(
            .WIDTH       (WIDTH),
            .KICK_CYCLES (KICK_CYCLES)
        ) u_ch (
            .i_clk    (i_clk),
            .i_arst   (i_arst),
            .i_load   (i_load),
            .i_speed  (i_speed[g*WIDTH +: WIDTH]),
            .i_run    (w_run),
            .i_tick   (w_tick),
            .i_cnt    (r_cnt),
            .o_pwm    (w_pwm[g]),
            .o_duty   (w_duty[g*WIDTH +: WIDTH]),
            .o_idle   (w_idle[g]),
            .o_active (w_active[g])
        );
    end

    assign o_pwm_out  = w_pwm;
    assign o_duty     = w_duty;
    assign o_chs_mode = r_chs_mode;
    assign o_busy     = r_pending || (|w_active);

endmodule
